led_pattern_seq: RTL



---
 rtl/led_pattern_seq.sv | 139 +++++++++++++
 1 files changed

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: six selectable N-LED patterns stepped by an internal
// clock divider, with run/stop and one-shot (single frame) operation.
module led_pattern_seq #(
    parameter int N_LEDS   = 8,
    parameter int STEP_DIV = 12500000,
    parameter int DIV_W    = 24
) (
    input  logic              clk_50M,
    input  logic              rst_n,
    input  logic              run,
    input  logic              oneshot,
    input  logic [2:0]        mode,
    output logic [N_LEDS-1:0] led,
    output logic              step_tick,
    output logic              frame_done,
    output logic              active
);
    // state | meaning
    // IDLE  | outputs dark, waiting for run (re-armed by run low after a one-shot)
    // RUN   | divider counting, led shows pattern(mode_q, step)
    localparam int H  = N_LEDS / 2;
    localparam int SW = $clog2(2 * N_LEDS - 2);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t            state, state_nxt;
    logic [2:0]        mode_q, mode_q_nxt;
    logic [SW-1:0]     step, step_nxt;
    logic [DIV_W-1:0]  div, div_nxt;
    logic              blocked, blocked_nxt;
    logic              adv, last;
    logic [N_LEDS-1:0] led_nxt;
    logic              tick_nxt, done_nxt, active_nxt;

    function automatic logic [N_LEDS-1:0] pattern(input logic [2:0] m, input int k);
        logic [N_LEDS-1:0] p;
        p = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            case (m)
                3'd0:    p[i] = (k < H) && (i >= H - 1 - k) && (i <= H + k);
                3'd1:    p[i] = (k < H) && (i >= k) && (i <= N_LEDS - 1 - k);
                3'd2:    p[i] = (i == k);
                3'd3:    p[i] = (i == N_LEDS - 1 - k);
                3'd4:    p[i] = (k < N_LEDS) ? (i == k) : (i == 2 * N_LEDS - 2 - k);
                3'd5:    p[i] = (k == 0);
                default: p[i] = 1'b0;
            endcase
        end
        return p;
    endfunction

    function automatic int period(input logic [2:0] m);
        case (m)
            3'd0, 3'd1: return H + 1;
            3'd2, 3'd3: return N_LEDS;
            3'd4:       return 2 * N_LEDS - 2;
            3'd5:       return 2;
            default:    return 1;
        endcase
    endfunction

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            mode_q     <= '0;
            step       <= '0;
            div        <= '0;
            blocked    <= 1'b0;
            led        <= '0;
            step_tick  <= 1'b0;
            frame_done <= 1'b0;
            active     <= 1'b0;
        end else begin
            state      <= state_nxt;
            mode_q     <= mode_q_nxt;
            step       <= step_nxt;
            div        <= div_nxt;
            blocked    <= blocked_nxt;
            led        <= led_nxt;
            step_tick  <= tick_nxt;
            frame_done <= done_nxt;
            active     <= active_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        mode_q_nxt  = mode_q;
        step_nxt    = step;
        div_nxt     = div;
        blocked_nxt = blocked;
        adv         = 1'b0;
        last        = (int'(step) == period(mode_q) - 1);
        case (state)
            S_IDLE: begin
                // blocked holds off a held-high run after a one-shot frame
                if (!run) begin
                    blocked_nxt = 1'b0;
                end else if (!blocked) begin
                    state_nxt  = S_RUN;
                    mode_q_nxt = mode;
                    step_nxt   = '0;
                    div_nxt    = '0;
                end
            end
            S_RUN: begin
                if (!run) begin
                    state_nxt = S_IDLE;
                    step_nxt  = '0;
                    div_nxt   = '0;
                end else if (div == DIV_W'(STEP_DIV - 1)) begin
                    adv     = 1'b1;
                    div_nxt = '0;
                    if (last) begin
                        step_nxt = '0;
                        if (oneshot) begin
                            state_nxt   = S_IDLE;
                            blocked_nxt = 1'b1;
                        end else begin
                            mode_q_nxt = mode;
                        end
                    end else begin
                        step_nxt = step + SW'(1);
                    end
                end else begin
                    div_nxt = div + DIV_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        led_nxt    = (state_nxt == S_RUN) ? pattern(mode_q_nxt, int'(step_nxt)) : '0;
        tick_nxt   = adv;
        done_nxt   = adv && last;
        active_nxt = (state_nxt == S_RUN);
    end
endmodule
